mem_bus_arbiter: RTL

//  Shares the single memory port between the data cache (requester D) and the instruction cache bank (requester I).
//  - Grants one requester per cycle and forwards its command, address and data to memory.
//  - Records which requester owns each outstanding load tag, and routes returning tags only to that owner.
//  - Sits between icache_bank/dcache and the memory interface in the processor top.

---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/mem_bus_arbiter_tag_owner_table.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_bus_arbiter_pkg: shared bus command, FSM and requester types   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_D = 1'b0,
    REQ_I = 1'b1
  } req_id_e;

  localparam int C_ADDR_W = 32;
  localparam int C_DATA_W = 64;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_tag_owner_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_bus_arbiter_tag_owner_table: valid+owner record per load tag   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_bus_arbiter_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16,
  parameter int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_en,
  input  logic [TAG_W-1:0] i_set_tag,
  input  req_id_e          i_set_owner,
  input  logic             i_clr_en,
  input  logic [TAG_W-1:0] i_clr_tag,
  input  logic [TAG_W-1:0] i_lk_tag,
  output logic             o_lk_valid,
  output req_id_e          o_lk_owner,
  input  logic [TAG_W-1:0] i_chk_tag,
  output logic             o_chk_valid
);

  logic [NUM_TAGS-1:0] r_valid;
  logic [NUM_TAGS-1:0] r_owner;

  // Set is applied after clear so a tag returned and re-issued in one cycle stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_owner <= '0;
    end else begin
      if (i_clr_en) r_valid[i_clr_tag] <= 1'b0;
      if (i_set_en) begin
        r_valid[i_set_tag] <= 1'b1;
        r_owner[i_set_tag] <= i_set_owner;
      end
    end
  end

  assign o_lk_valid  = r_valid[i_lk_tag];
  assign o_lk_owner  = req_id_e'(r_owner[i_lk_tag]);
  assign o_chk_valid = r_valid[i_chk_tag];

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_bus_arbiter: shares the memory port between dcache and icache  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4,
  localparam int TAG_W       = $clog2(NUM_TAGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          d_command,
  input  logic [C_ADDR_W-1:0] d_addr,
  input  logic [C_DATA_W-1:0] d_data,
  input  logic [1:0]          i_command,
  input  logic [C_ADDR_W-1:0] i_addr,
  input  logic [TAG_W-1:0]    mem2proc_response,
  input  logic [C_DATA_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]    mem2proc_tag,
  output logic [1:0]          proc2mem_command,
  output logic [C_ADDR_W-1:0] proc2mem_addr,
  output logic [C_DATA_W-1:0] proc2mem_data,
  output logic [TAG_W-1:0]    d_response,
  output logic [TAG_W-1:0]    i_response,
  output logic [TAG_W-1:0]    d_tag,
  output logic [TAG_W-1:0]    i_tag,
  output logic [C_DATA_W-1:0] mem_data_out,
  output logic                tag_err
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       r_state, w_state_nxt;
  req_id_e          r_lock, w_lock_nxt, w_grant, w_lk_owner;
  logic [CNT_W-1:0] r_starve, w_starve_nxt;
  logic [1:0]       w_cmd;
  logic             w_d_req, w_i_req, w_grant_vld, w_i_granted;
  logic             w_active, w_accept, w_set, w_ret, w_lk_valid, w_chk_valid;

  assign w_d_req = (d_command != BUS_NONE);
  assign w_i_req = (i_command != BUS_NONE);

  // D wins unless I has starved; with I idle a saturated counter must not block D.
  always_comb begin
    w_grant     = REQ_D;
    w_grant_vld = 1'b0;
    if (r_state == ARB_HOLD) begin
      w_grant     = r_lock;
      w_grant_vld = 1'b1;
    end else if (w_d_req && ((r_starve < C_LIMIT) || !w_i_req)) begin
      w_grant     = REQ_D;
      w_grant_vld = 1'b1;
    end else if (w_i_req) begin
      w_grant     = REQ_I;
      w_grant_vld = 1'b1;
    end
  end

  assign w_cmd       = !w_grant_vld ? 2'(BUS_NONE) : ((w_grant == REQ_I) ? i_command : d_command);
  assign w_active    = (w_cmd != BUS_NONE);
  assign w_accept    = w_active && (mem2proc_response != '0);
  assign w_set       = w_accept && (w_cmd == BUS_LOAD);
  assign w_ret       = (mem2proc_tag != '0);
  assign w_i_granted = w_grant_vld && (w_grant == REQ_I);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_lock   <= REQ_D;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lock   <= w_lock_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = ARB_IDLE;
    w_lock_nxt   = r_lock;
    w_starve_nxt = r_starve;
    if (w_active && (mem2proc_response == '0)) begin
      w_state_nxt = ARB_HOLD;
      w_lock_nxt  = w_grant;
    end
    if (w_i_granted && w_accept) begin
      w_starve_nxt = '0;
    end else if (w_i_req && !w_i_granted && (r_starve < C_LIMIT)) begin
      w_starve_nxt = r_starve + CNT_W'(1);
    end
  end

  mem_bus_arbiter_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_table (
    .clk         (clock),
    .rst         (reset),
    .i_set_en    (w_set),
    .i_set_tag   (mem2proc_response),
    .i_set_owner (w_grant),
    .i_clr_en    (w_ret && w_lk_valid),
    .i_clr_tag   (mem2proc_tag),
    .i_lk_tag    (mem2proc_tag),
    .o_lk_valid  (w_lk_valid),
    .o_lk_owner  (w_lk_owner),
    .i_chk_tag   (mem2proc_response),
    .o_chk_valid (w_chk_valid)
  );

  // Everything is forced quiet while reset is held, independent of the clock.
  always_comb begin
    proc2mem_command = 2'(BUS_NONE);
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    d_response       = '0;
    i_response       = '0;
    d_tag            = '0;
    i_tag            = '0;
    mem_data_out     = '0;
    tag_err          = 1'b0;
    if (!reset) begin
      proc2mem_command = w_cmd;
      mem_data_out     = mem2proc_data;
      if (w_active) begin
        proc2mem_addr = (w_grant == REQ_I) ? i_addr : d_addr;
        proc2mem_data = (w_grant == REQ_I) ? '0 : d_data;
        if (w_grant == REQ_I) i_response = mem2proc_response;
        else                  d_response = mem2proc_response;
      end
      if (w_ret && w_lk_valid) begin
        if (w_lk_owner == REQ_I) i_tag = mem2proc_tag;
        else                     d_tag = mem2proc_tag;
      end
      tag_err = (w_ret && !w_lk_valid) ||
                (w_set && w_chk_valid && (mem2proc_tag != mem2proc_response));
    end
  end

endmodule
`default_nettype wire
